// File: rtl/neopixel_driver.sv
// WS2812 ("NeoPixel") frame driver: fetches NUM_PIXELS GRB words from an external
// pixel memory, serialises each MSB first, then holds the line low to latch the frame.
module neopixel_driver #(
  parameter int NUM_PIXELS = 8,
  parameter int T0H        = 18,
  parameter int T1H        = 35,
  parameter int TBIT       = 63,
  parameter int TRESET     = 3000
) (
  input  logic                                                clock,
  input  logic                                                reset_n,
  input  logic                                                start,
  output logic [$clog2(NUM_PIXELS > 1 ? NUM_PIXELS : 2)-1:0] pixel_addr,
  output logic                                                pixel_re,
  input  logic [23:0]                                         pixel_data,
  output logic                                                serial_out,
  output logic                                                busy,
  output logic                                                done
);

  localparam int AW = $clog2(NUM_PIXELS > 1 ? NUM_PIXELS : 2);
  localparam int CW = $clog2(TBIT > 1 ? TBIT : 2);
  localparam int LW = $clog2(TRESET > 1 ? TRESET : 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  localparam logic [CW-1:0] T0H_C      = CW'(T0H);
  localparam logic [CW-1:0] T1H_C      = CW'(T1H);
  localparam logic [CW-1:0] TBIT_LAST  = CW'(TBIT - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(TRESET - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_PIXELS - 1);

  logic [1:0]    state_r, state_s;
  logic [CW-1:0] cyc_r, cyc_s;
  logic [4:0]    bit_r, bit_s;
  logic [23:0]   shift_r, shift_s;
  logic [AW-1:0] idx_r, idx_s;
  logic [LW-1:0] lat_r, lat_s;
  logic          done_s;
  logic          high_s;

  // Next-state logic; outputs are derived from the next-state values so they can be registered.
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    idx_s   = idx_r;
    lat_s   = lat_r;
    done_s  = 1'b0;
    high_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FETCH;
          idx_s   = {AW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        shift_s = pixel_data;
        cyc_s   = {CW{1'b0}};
        bit_s   = 5'd0;
        state_s = SEND;
      end
      SEND: begin
        if (cyc_r == TBIT_LAST) begin
          cyc_s   = {CW{1'b0}};
          shift_s = {shift_r[22:0], 1'b0};
          if (bit_r == 5'd23) begin
            if (idx_r < IDX_LAST) begin
              idx_s   = idx_r + AW'(1);
              state_s = FETCH;
            end else begin
              state_s = LATCH;
              lat_s   = {LW{1'b0}};
            end
          end else begin
            bit_s = bit_r + 5'd1;
          end
        end else begin
          cyc_s = cyc_r + CW'(1);
        end
      end
      LATCH: begin
        if (lat_r == LATCH_LAST) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          lat_s = lat_r + LW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // High phase length depends on the bit currently at the top of the shift register.
    if (state_s == SEND) begin
      if (shift_s[23]) begin
        high_s = (cyc_s < T1H_C);
      end else begin
        high_s = (cyc_s < T0H_C);
      end
    end else begin
      high_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cyc_r      <= {CW{1'b0}};
      bit_r      <= 5'd0;
      shift_r    <= 24'd0;
      idx_r      <= {AW{1'b0}};
      lat_r      <= {LW{1'b0}};
      pixel_addr <= {AW{1'b0}};
      pixel_re   <= 1'b0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cyc_r      <= cyc_s;
      bit_r      <= bit_s;
      shift_r    <= shift_s;
      idx_r      <= idx_s;
      lat_r      <= lat_s;
      pixel_addr <= idx_s;
      pixel_re   <= (state_s == FETCH);
      serial_out <= high_s;
      busy       <= (state_s != IDLE);
      done       <= done_s;
    end
  end

endmodule

// File: tb/tb_neopixel_driver.sv
// Scoreboard bench for neopixel_driver: stimulus queues expected pulse widths, gaps,
// fetch addresses and done times; a negedge monitor pops and compares them.
module tb_neopixel_driver;

  localparam int NPIX   = 2;
  localparam int T0H    = 18;
  localparam int T1H    = 35;
  localparam int TBIT   = 63;
  localparam int TRESET = 3000;
  localparam int LAT    = 6026;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [0:0]  pixel_addr;
  logic        pixel_re;
  logic [23:0] pixel_data;
  logic        serial_out;
  logic        busy;
  logic        done;

  logic [23:0] mem [0:1];
  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  int last_low = 0;
  int exp_high[$];
  int exp_gap[$];
  int exp_addr[$];
  int exp_done[$];

  neopixel_driver #(
    .NUM_PIXELS(NPIX), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pixel_addr(pixel_addr),
    .pixel_re(pixel_re), .pixel_data(pixel_data), .serial_out(serial_out),
    .busy(busy), .done(done)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;
  assign pixel_data = pixel_re ? mem[pixel_addr] : 24'h5A5A5A;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  function automatic void unexpected(string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=event expected=none (cycle %0d)", name, cyc_cnt);
  endfunction

  // Expected pulse train for one frame built from the current memory contents.
  task automatic push_frame(input bit contiguous);
    int prev_low = -1;
    logic [23:0] word;
    bit bitv;
    int hi;
    for (int p = 0; p < NPIX; p++) begin
      exp_addr.push_back(p);
      word = mem[p];
      for (int b = 23; b >= 0; b--) begin
        bitv = word[b];
        hi = bitv ? T1H : T0H;
        if (prev_low < 0) exp_gap.push_back(contiguous ? last_low + TRESET + 2 : -1);
        else exp_gap.push_back(prev_low + ((b == 23) ? 1 : 0));
        exp_high.push_back(hi);
        prev_low = TBIT - hi;
      end
    end
    last_low = prev_low;
  endtask

  task automatic pulse_start(output int samp);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    samp = cyc_cnt;
    exp_done.push_back(samp + LAT);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int low_busy = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clock);
      n++;
      if (done) seen = 1'b1;
      else if (!busy) low_busy++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: actual=no done expected=done within %0d cycles", budget);
    end else begin
      check("busy_during_frame", low_busy, 0);
      check("busy_at_done", busy, 0);
    end
  endtask

  // Monitor: measures serial_out run lengths and watches pixel_re / done.
  logic prev_s = 1'b0;
  int hi_len = 0;
  int lo_len = 0;
  int g;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_s = 1'b0;
      hi_len = 0;
      lo_len = 0;
    end else begin
      if (serial_out) begin
        if (!prev_s) begin
          if (exp_gap.size() == 0) unexpected("extra_pulse");
          else begin
            g = exp_gap.pop_front();
            if (g >= 0) check("low_gap", lo_len, g);
          end
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev_s) begin
          if (exp_high.size() == 0) unexpected("extra_high");
          else check("high_width", hi_len, exp_high.pop_front());
          lo_len = 0;
        end
        lo_len++;
      end
      prev_s = serial_out;
      if (pixel_re) begin
        if (exp_addr.size() == 0) unexpected("extra_pixel_re");
        else check("pixel_addr", int'(pixel_addr), exp_addr.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("extra_done");
        else check("done_cycle", cyc_cnt, exp_done.pop_front());
      end
    end
  end

  int s;
  int highs;
  initial begin
    repeat (2) @(negedge clock);
    check("reset_state", int'({serial_out, busy, done, pixel_re, pixel_addr}), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_state", int'({serial_out, busy, done, pixel_re, pixel_addr}), 0);

    // Frame with distinctive first/last bits of pixel 0.
    mem[0] = 24'h800001;
    mem[1] = 24'h000000;
    push_frame(1'b0);
    pulse_start(s);
    wait_done(LAT + 50);
    repeat (20) @(negedge clock);

    // Mixed data pattern.
    mem[0] = 24'hA5C3F0;
    mem[1] = 24'h0F0F81;
    push_frame(1'b0);
    pulse_start(s);
    wait_done(LAT + 50);
    repeat (20) @(negedge clock);

    // start pulsed during pixel 1 must be ignored.
    mem[0] = 24'h800001;
    mem[1] = 24'h000000;
    push_frame(1'b0);
    pulse_start(s);
    while (cyc_cnt < s + 1 + 24 * TBIT + 1 + 300) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(LAT);
    repeat (100) @(negedge clock);
    check("no_extra_frame", exp_high.size() + exp_gap.size() + exp_addr.size() + exp_done.size(), 0);

    // Asynchronous reset during bit 5 of pixel 0.
    push_frame(1'b0);
    pulse_start(s);
    while (cyc_cnt < s + 2 + 5 * TBIT + 5) @(negedge clock);
    check("pre_reset_high", serial_out, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_serial_immediate", serial_out, 0);
    check("reset_busy_immediate", busy, 0);
    exp_high.delete();
    exp_gap.delete();
    exp_addr.delete();
    exp_done.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (serial_out || busy) highs++;
    end
    check("post_reset_quiet", highs, 0);

    // start held high: three back-to-back frames.
    push_frame(1'b0);
    push_frame(1'b1);
    push_frame(1'b1);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    s = cyc_cnt;
    exp_done.push_back(s + LAT);
    exp_done.push_back(s + (LAT + 1) + LAT);
    exp_done.push_back(s + 2 * (LAT + 1) + LAT);
    wait_done(LAT + 50);
    wait_done(LAT + 50);
    @(negedge clock);
    start = 1'b0;
    wait_done(LAT + 50);
    repeat (100) @(negedge clock);
    check("queues_drained", exp_high.size() + exp_gap.size() + exp_addr.size() + exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neopixel_driver.md
NEOPIXEL_DRIVER -- requirements
Module: neopixel_driver

Interface
REQ-001 Parameter NUM_PIXELS, default 8: number of pixels in one frame (>=1).
REQ-002 Parameter T0H, default 18: high time of a 0 bit, in clock cycles.
REQ-003 Parameter T1H, default 35: high time of a 1 bit, in clock cycles (T0H < T1H < TBIT).
REQ-004 Parameter TBIT, default 63: total bit period, in clock cycles.
REQ-005 Parameter TRESET, default 3000: latch (low) time after the last bit, in clock cycles.
REQ-006 clock  input  1  system clock (50 MHz); all state updates on posedge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to send one frame; sampled only in IDLE.
REQ-009 pixel_addr  output  $clog2(NUM_PIXELS) (min 1)  pixel memory address.
REQ-010 pixel_re  output  1  pixel memory read enable.
REQ-011 pixel_data  input  24  GRB word, valid combinationally while pixel_re=1.
REQ-012 serial_out  output  1  WS2812 data line.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, SEND, LATCH.
REQ-016 IDLE: start=1 -> FETCH with pixel index 0; start=0 -> stay in IDLE.
REQ-017 FETCH: lasts exactly 1 cycle, with pixel_re=1 and pixel_addr=current index; pixel_data is loaded into the 24-bit shift register on the edge leaving FETCH; next state is SEND.
REQ-018 pixel_re SHALL be 0 in every state except FETCH; pixel_addr holds the current index in all states.
REQ-019 SEND: the 24 bits are sent MSB first (G[7] first, B[0] last), each bit lasting exactly TBIT cycles.
REQ-020 Within a bit period, serial_out=1 for the first T1H cycles (bit=1) or the first T0H cycles (bit=0), then 0 for the rest of the period.
REQ-021 The bit-cycle counter and the bit counter (0..23) SHALL be cleared on entry to SEND; the shift register shifts left once at the end of each bit period.
REQ-022 End of bit 23: if index < NUM_PIXELS-1, increment index and go to FETCH; otherwise go to LATCH.
REQ-023 serial_out SHALL be 0 in IDLE, FETCH and LATCH (the FETCH cycle adds 1 low cycle between pixels).
REQ-024 LATCH: hold serial_out=0 for exactly TRESET cycles, then go to IDLE; done=1 in the first IDLE cycle only.
REQ-025 busy SHALL be 1 in FETCH, SEND and LATCH, and 0 in IDLE.
REQ-026 start asserted while busy=1 SHALL be ignored (no queuing); start held high continuously SHALL begin a new frame in the first IDLE cycle after done.
REQ-027 Frame latency: done SHALL rise exactly NUM_PIXELS*(1+24*TBIT)+TRESET cycles after the edge that samples start.
REQ-028 Counter widths SHALL be sized from their parameters ($clog2); no counter may wrap during a frame.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, index=0, counters=0, shift register=0, serial_out=0, pixel_re=0, busy=0, done=0, regardless of state.
REQ-030 After reset_n deasserts mid-frame, no residual bits SHALL be emitted; the next frame starts only on a new start.

Verification (NUM_PIXELS=2, other parameters at default)
REQ-031 Memory {24'h800001, 24'h000000}, start pulse -> pixel 0: bit 0 high 35/low 28; bits 1-22 high 18/low 45; bit 23 high 35/low 28; then 1 low FETCH cycle; pixel 1: 24 bits of high 18/low 45.
REQ-032 Same frame -> done pulses once, exactly 6026 cycles after start is sampled; busy=1 throughout that interval and 0 afterwards.
REQ-033 pixel_re is observed high exactly twice per frame, with pixel_addr=0 and then pixel_addr=1, each for 1 cycle.
REQ-034 start pulsed again during SEND of pixel 1 -> ignored; exactly one done pulse and no extra frame.
REQ-035 reset_n driven low during bit 5 of pixel 0 -> serial_out=0, busy=0 without waiting for a clock edge; after release, serial_out stays 0 for 200 cycles with start=0.
REQ-036 start held at 1 continuously -> back-to-back frames, each beginning with a FETCH in the cycle right after done, with identical waveforms per frame.
